// File: rtl/fft_brev_reorder.sv
// fft_brev_reorder
//
// Converts bit-reversed FFT output frames back to natural bin order. Incoming
// frames are written to a ping-pong RAM at bit-reversed addresses while the
// previously completed frame is read out of the other bank in natural order.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_areset_n  asynchronous active-low reset
//   i_ce        clock enable: one word in and one output step per asserted cycle
//   i_sync      marks i_data as index 0 of a bit-reversed frame (qualified by i_ce)
//   i_data      bit-reversed-order sample
//   o_data      natural-order sample (registered)
//   o_sync      high while o_data is bin 0 of a frame
//   o_valid     o_data holds a bin of a complete frame

module fft_brev_reorder #(
  parameter int unsigned LGSIZE = 12,
  parameter int unsigned WIDTH  = 32
) (
  input  logic             i_clk,
  input  logic             i_areset_n,
  input  logic             i_ce,
  input  logic             i_sync,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sync,
  output logic             o_valid
);

  localparam int unsigned N = 2 ** LGSIZE;

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e              state_q, state_d;
  logic [LGSIZE-1:0]   wr_idx_q, wr_idx_d;
  logic                bank_q, bank_d;

  logic [WIDTH-1:0]    mem_q [2*N];

  logic                resync;
  logic                wr_en;
  logic                emit;
  logic [LGSIZE:0]     wr_addr;
  logic [LGSIZE:0]     rd_addr;

  function automatic logic [LGSIZE-1:0] brev(input logic [LGSIZE-1:0] v);
    logic [LGSIZE-1:0] r;
    for (int unsigned i = 0; i < LGSIZE; i++) begin
      r[i] = v[LGSIZE-1-i];
    end
    return r;
  endfunction

  // A sync anywhere but index 0 abandons the partial frame. In IDLE wr_idx is
  // always 0, so this never fires there.
  assign resync = i_sync && (wr_idx_q != '0);

  // State register
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= StIdle;
      wr_idx_q <= '0;
      bank_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      bank_q   <= bank_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    bank_d   = bank_q;
    if (i_ce) begin
      case (state_q)
        StIdle: begin
          if (i_sync) begin
            wr_idx_d = LGSIZE'(1);
            state_d  = StFill;
          end
        end
        StFill, StRun: begin
          if (resync) begin
            wr_idx_d = LGSIZE'(1);
            state_d  = StFill;
          end else begin
            wr_idx_d = wr_idx_q + LGSIZE'(1);
            if (&wr_idx_q) begin
              // Frame complete: it becomes the read bank for the next N steps.
              bank_d  = ~bank_q;
              state_d = StRun;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    wr_en   = i_ce && ((state_q != StIdle) || i_sync);
    wr_addr = {bank_q, resync ? {LGSIZE{1'b0}} : brev(wr_idx_q)};
    rd_addr = {~bank_q, wr_idx_q};
    emit    = i_ce && (state_q == StRun) && !resync;
  end

  // Frame RAM; write and read banks always differ, so no collision handling.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= i_data;
    end
  end

  // Registered read port and output flags
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_data  <= '0;
      o_sync  <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_ce) begin
      o_valid <= emit;
      o_sync  <= emit && (wr_idx_q == '0);
      if (emit) begin
        o_data <= mem_q[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_fft_brev_reorder.sv
module tb_fft_brev_reorder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LGSIZE=4 instance
  logic        rst_n, ce, sync;
  logic [31:0] data, o_data;
  logic        o_sync, o_valid;

  // LGSIZE=12 instance
  logic        rst12_n, ce12, sync12;
  logic [31:0] data12, o_data12;
  logic        o_sync12, o_valid12;

  int checks = 0;
  int errors = 0;

  fft_brev_reorder #(.LGSIZE(4), .WIDTH(32)) u_dut4 (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .i_ce       (ce),
    .i_sync     (sync),
    .i_data     (data),
    .o_data     (o_data),
    .o_sync     (o_sync),
    .o_valid    (o_valid)
  );

  fft_brev_reorder #(.LGSIZE(12), .WIDTH(32)) u_dut12 (
    .i_clk      (clk),
    .i_areset_n (rst12_n),
    .i_ce       (ce12),
    .i_sync     (sync12),
    .i_data     (data12),
    .o_data     (o_data12),
    .o_sync     (o_sync12),
    .o_valid    (o_valid12)
  );

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) begin
      r = r | (((v >> i) & 1) << (bits - 1 - i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic c, input logic s, input logic [31:0] d);
    ce = c; sync = s; data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step12(input logic s, input logic [31:0] d);
    ce12 = 1'b1; sync12 = s; data12 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ce = 1'b0; sync = 1'b0; data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Standard frame stream: step s carries brev(k)+16*frame, sync at k=0;
  // output after step s>=16 is bin s-16.
  task automatic frame_step(input int s, input string tag);
    step(1'b1, 1'((s % 16) == 0), 32'(brev(s % 16, 4) + 16 * (s / 16)));
    if (s < 16) begin
      chk({tag, "_fill_valid"}, 32'(o_valid), 32'd0);
    end else begin
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_data"}, o_data, 32'(s - 16));
      chk({tag, "_sync"}, 32'(o_sync), 32'((s % 16) == 0));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        c;
    int          s, syncs, guard;
    logic        exp_v, exp_s;
    logic [31:0] exp_d;

    rst_n = 1'b0; ce = 1'b0; sync = 1'b0; data = '0;
    rst12_n = 1'b0; ce12 = 1'b0; sync12 = 1'b0; data12 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sync", 32'(o_sync), 32'd0);
    chk("rst_data", o_data, 32'd0);
    rst_n = 1'b1;

    // Words before any sync are discarded.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'hDEAD_0000 | 32'(k));
      chk("pre_sync_valid", 32'(o_valid), 32'd0);
    end

    // Continuous i_ce: frames 0,1 emerge as 0..31.
    for (int i = 0; i < 48; i++) frame_step(i, "cont");

    // Random ~50% i_ce; outputs must freeze on idle cycles.
    do_reset();
    @(negedge clk);
    s = 0; syncs = 0; guard = 0;
    exp_v = 1'b0; exp_s = 1'b0; exp_d = '0;
    while (s < 48 && guard < 1000) begin
      guard++;
      c = 1'($urandom_range(0, 1));
      if (c) begin
        step(1'b1, 1'((s % 16) == 0), 32'(brev(s % 16, 4) + 16 * (s / 16)));
        if (s >= 16) begin
          exp_v = 1'b1; exp_d = 32'(s - 16); exp_s = 1'((s % 16) == 0);
        end
        s++;
        if (o_sync) syncs++;
      end else begin
        step(1'b0, 1'b0, 32'hBAD0_BAD0);
      end
      chk("rce_valid", 32'(o_valid), 32'(exp_v));
      chk("rce_data", o_data, exp_d);
      chk("rce_sync", 32'(o_sync), 32'(exp_s));
    end
    chk("rce_steps_done", 32'(s), 32'd48);
    chk("rce_sync_count", 32'(syncs), 32'd2);

    // Resync at step 7 of frame 2.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 39; i++) frame_step(i, "pre_resync");
    step(1'b1, 1'b1, 32'h100);
    chk("resync_valid", 32'(o_valid), 32'd0);
    chk("resync_sync", 32'(o_sync), 32'd0);
    for (int t = 1; t < 16; t++) begin
      step(1'b1, 1'b0, 32'(brev(t, 4) + 'h100));
      chk("resync_fill_valid", 32'(o_valid), 32'd0);
    end
    for (int t = 0; t < 16; t++) begin
      step(1'b1, 1'(t == 0), 32'(brev(t, 4) + 'h200));
      chk("resync_out_valid", 32'(o_valid), 32'd1);
      chk("resync_out_data", o_data, 32'(t + 'h100));
      chk("resync_out_sync", 32'(o_sync), 32'(t == 0));
    end

    // Asynchronous reset between edges while in RUN.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(o_valid), 32'd0);
    chk("areset_sync", 32'(o_sync), 32'd0);
    chk("areset_data", o_data, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 16; t++) begin
      step(1'b1, 1'(t == 0), 32'(brev(t, 4) + 'h300));
      chk("post_rst_fill_valid", 32'(o_valid), 32'd0);
    end
    for (int t = 0; t < 16; t++) begin
      step(1'b1, 1'(t == 0), 32'(brev(t, 4) + 'h400));
      chk("post_rst_valid", 32'(o_valid), 32'd1);
      chk("post_rst_data", o_data, 32'(t + 'h300));
      chk("post_rst_sync", 32'(o_sync), 32'(t == 0));
    end
    ce = 1'b0;

    // LGSIZE=12: single initial sync, back-to-back frames; step s carries s.
    rst12_n = 1'b1;
    @(negedge clk);
    syncs = 0;
    for (int i = 0; i < 3 * 4096; i++) begin
      step12(1'(i == 0), 32'(i));
      if (i < 4096) begin
        if (o_valid12) begin
          chk("n4096_fill_valid", 32'(o_valid12), 32'd0);
        end
      end else begin
        if (o_sync12) syncs++;
        chk("n4096_data", o_data12,
            32'(4096 * ((i - 4096) / 4096) + brev((i - 4096) % 4096, 12)));
        chk("n4096_sync", 32'(o_sync12), 32'(((i - 4096) % 4096) == 0));
      end
    end
    chk("n4096_valid_end", 32'(o_valid12), 32'd1);
    chk("n4096_sync_count", 32'(syncs), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
